// File: rtl/plan_sequencer.sv
// Travel-plan sequencer: queues plan words and steps through their 2-bit maneuver
// codes on line gaps. Bumper hits pause motion until the bumper has stayed clear.
//
// state      | meaning
// -----------+----------------------------------------------------------------
// S_IDLE     | stopped, pops the next queued plan when one is available
// S_FOLLOW   | following the line, counting line-absent cycles for a gap
// S_MANEUVER | nav controller is executing mnv, waiting for mnv_done
// S_BLOCKED  | obstructed, buzzer on, waiting for CLR_CYC bump-free cycles
module plan_sequencer #(
    parameter int PLAN_W  = 16,
    parameter int DEPTH   = 4,
    parameter int GAP_CYC = 8,
    parameter int CLR_CYC = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PLAN_W-1:0]          plan,
    input  logic                       plan_vld,
    input  logic                       line_present,
    input  logic                       bump,
    input  logic                       mnv_done,
    output logic                       go,
    output logic [1:0]                 mnv,
    output logic                       mnv_strt,
    output logic                       buzz_en,
    output logic                       plan_full,
    output logic [$clog2(DEPTH+1)-1:0] plan_cnt,
    output logic                       ovf,
    output logic                       idle
);
    localparam int CW    = $clog2(DEPTH+1);
    localparam int PW    = $clog2(DEPTH);
    localparam int STEPS = PLAN_W/2;
    localparam int SW    = $clog2(STEPS+1);
    localparam int GW    = $clog2(GAP_CYC+1);
    localparam int KW    = $clog2(CLR_CYC+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC-1);
    localparam logic [KW-1:0] CLR_LAST = KW'(CLR_CYC-1);

    typedef enum logic [1:0] {S_IDLE, S_FOLLOW, S_MANEUVER, S_BLOCKED} state_t;

    state_t            state, state_nxt;
    logic              origin_man, origin_nxt;
    logic              done_seen, done_nxt;
    logic [PLAN_W-1:0] shift_q, shift_nxt;
    logic [SW-1:0]     step_q, step_nxt;
    logic [GW-1:0]     gap_q, gap_nxt;
    logic              armed_q, armed_nxt;
    logic [KW-1:0]     clr_q, clr_nxt;
    logic              go_nxt, strt_nxt, buzz_nxt, ovf_nxt, full_nxt;
    logic [1:0]        mnv_nxt;
    logic [CW-1:0]     cnt_nxt;
    logic              push, pop, gap_hit;

    logic [PLAN_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;

    always_comb begin
        state_nxt  = state;
        origin_nxt = origin_man;
        done_nxt   = done_seen;
        shift_nxt  = shift_q;
        step_nxt   = step_q;
        gap_nxt    = gap_q;
        armed_nxt  = armed_q | line_present;
        clr_nxt    = clr_q;
        go_nxt     = go;
        mnv_nxt    = mnv;
        strt_nxt   = 1'b0;
        buzz_nxt   = buzz_en;
        pop        = 1'b0;
        gap_hit    = 1'b0;

        case (state)
            S_IDLE: begin
                if (plan_cnt != '0) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    step_nxt  = '0;
                    gap_nxt   = '0;
                    go_nxt    = 1'b1;
                    state_nxt = S_FOLLOW;
                end
            end
            S_FOLLOW: begin
                // a qualified gap disarms counting until the line is seen again
                if (line_present || !armed_q) begin
                    gap_nxt = '0;
                end else if (gap_q == GAP_LAST) begin
                    gap_hit   = 1'b1;
                    gap_nxt   = '0;
                    armed_nxt = 1'b0;
                end else begin
                    gap_nxt = gap_q + GW'(1);
                end

                if (bump) begin
                    gap_nxt    = '0;
                    armed_nxt  = armed_q | line_present;
                    go_nxt     = 1'b0;
                    buzz_nxt   = 1'b1;
                    origin_nxt = 1'b0;
                    done_nxt   = 1'b0;
                    clr_nxt    = '0;
                    state_nxt  = S_BLOCKED;
                end else if (gap_hit) begin
                    if (shift_q[1:0] == 2'b00 || step_q == LAST_STEP) begin
                        go_nxt    = 1'b0;
                        state_nxt = S_IDLE;
                    end else begin
                        mnv_nxt   = shift_q[1:0];
                        strt_nxt  = 1'b1;
                        shift_nxt = shift_q >> 2;
                        step_nxt  = step_q + SW'(1);
                        state_nxt = S_MANEUVER;
                    end
                end
            end
            S_MANEUVER: begin
                gap_nxt = '0;
                if (bump) begin
                    go_nxt     = 1'b0;
                    buzz_nxt   = 1'b1;
                    origin_nxt = 1'b1;
                    done_nxt   = mnv_done;
                    clr_nxt    = '0;
                    state_nxt  = S_BLOCKED;
                end else if (mnv_done) begin
                    state_nxt = S_FOLLOW;
                end
            end
            S_BLOCKED: begin
                gap_nxt  = '0;
                done_nxt = done_seen | mnv_done;
                if (bump) begin
                    clr_nxt = '0;
                end else if (clr_q == CLR_LAST) begin
                    clr_nxt  = '0;
                    buzz_nxt = 1'b0;
                    go_nxt   = 1'b1;
                    // a maneuver finished while blocked resumes line following instead
                    if (origin_man && !done_nxt) begin
                        strt_nxt  = 1'b1;
                        state_nxt = S_MANEUVER;
                    end else begin
                        state_nxt = S_FOLLOW;
                    end
                end else begin
                    clr_nxt = clr_q + KW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        push    = plan_vld && (plan_cnt != FULL_CNT || pop);
        ovf_nxt = ovf | (plan_vld && !push);
        cnt_nxt = plan_cnt;
        if (push && !pop)
            cnt_nxt = plan_cnt + CW'(1);
        else if (pop && !push)
            cnt_nxt = plan_cnt - CW'(1);
        full_nxt = (cnt_nxt == FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            origin_man <= 1'b0;
            done_seen  <= 1'b0;
            shift_q    <= '0;
            step_q     <= '0;
            gap_q      <= '0;
            armed_q    <= 1'b1;
            clr_q      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            plan_cnt   <= '0;
            plan_full  <= 1'b0;
            ovf        <= 1'b0;
            go         <= 1'b0;
            mnv        <= 2'b00;
            mnv_strt   <= 1'b0;
            buzz_en    <= 1'b0;
            idle       <= 1'b1;
        end else begin
            state      <= state_nxt;
            origin_man <= origin_nxt;
            done_seen  <= done_nxt;
            shift_q    <= shift_nxt;
            step_q     <= step_nxt;
            gap_q      <= gap_nxt;
            armed_q    <= armed_nxt;
            clr_q      <= clr_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            plan_cnt   <= cnt_nxt;
            plan_full  <= full_nxt;
            ovf        <= ovf_nxt;
            go         <= go_nxt;
            mnv        <= mnv_nxt;
            mnv_strt   <= strt_nxt;
            buzz_en    <= buzz_nxt;
            idle       <= (state_nxt == S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= plan;
    end
endmodule

// File: tb/tb_plan_sequencer.sv
// Directed and randomized bench for plan_sequencer; expected maneuvers are derived
// from the plan words, queued plans are tracked in a bench-side queue.
module tb_plan_sequencer;
    localparam int STEPS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] plan = '0;
    logic        plan_vld = 1'b0;
    logic        line_present = 1'b1;
    logic        bump = 1'b0;
    logic        mnv_done = 1'b0;
    logic        go;
    logic [1:0]  mnv;
    logic        mnv_strt;
    logic        buzz_en;
    logic        plan_full;
    logic [2:0]  plan_cnt;
    logic        ovf;
    logic        idle;

    int          tests = 0;
    int          fails = 0;
    logic [1:0]  exp_mnv = 2'b00;
    logic [15:0] q[$];

    plan_sequencer dut (
        .clk(clk), .rst(rst), .plan(plan), .plan_vld(plan_vld),
        .line_present(line_present), .bump(bump), .mnv_done(mnv_done),
        .go(go), .mnv(mnv), .mnv_strt(mnv_strt), .buzz_en(buzz_en),
        .plan_full(plan_full), .plan_cnt(plan_cnt), .ovf(ovf), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_plan(input logic [15:0] p);
        plan = p;
        plan_vld = 1'b1;
        tick();
        plan_vld = 1'b0;
    endtask

    // push into an empty FIFO while idle; the plan is popped and go rises next cycle
    task automatic start_plan(input logic [15:0] p);
        push_plan(p);
        chk("start_cnt", plan_cnt, 1);
        tick();
        chk("start_go", go, 1);
        chk("start_cnt_pop", plan_cnt, 0);
        chk("start_idle", idle, 0);
    endtask

    task automatic bump_seq(input int b, input bit man, input bit dn, output bit still_man);
        bump = 1'b1;
        tick();
        chk("blk_go", go, 0);
        chk("blk_buzz", buzz_en, 1);
        repeat (b-1) tick();
        bump = 1'b0;
        if (dn) begin
            mnv_done = 1'b1;
            tick();
            mnv_done = 1'b0;
            repeat (14) tick();
        end else begin
            repeat (15) tick();
        end
        chk("blk_hold_go", go, 0);
        chk("blk_hold_buzz", buzz_en, 1);
        tick();
        chk("clr_go", go, 1);
        chk("clr_buzz", buzz_en, 0);
        chk("clr_strt", mnv_strt, man && !dn);
        chk("clr_mnv", mnv, exp_mnv);
        still_man = man && !dn;
        if (still_man) begin
            tick();
            chk("clr_strt_1cyc", mnv_strt, 0);
        end
    endtask

    // mode 0: clean gaps; 1: random dropouts and bumps; 2: 7-cycle dropout before each gap
    task automatic run_plan(input logic [15:0] p, input int mode);
        bit         man;
        logic [1:0] c;
        int         d;
        for (int i = 0; i <= STEPS; i++) begin
            c = (i < STEPS) ? 2'(p >> (2*i)) : 2'b00;
            line_present = 1'b1;
            tick();
            tick();
            if (mode == 1 && $urandom_range(0, 3) == 0)
                bump_seq($urandom_range(1, 3), 1'b0, 1'b0, man);
            if (mode != 0) begin
                d = (mode == 2) ? 7 : $urandom_range(1, 7);
                line_present = 1'b0;
                repeat (d) begin
                    tick();
                    chk("dropout_strt", mnv_strt, 0);
                end
                line_present = 1'b1;
                tick();
                chk("dropout_go", go, 1);
            end
            line_present = 1'b0;
            repeat (7) tick();
            chk("pregap_strt", mnv_strt, 0);
            chk("pregap_go", go, 1);
            tick();
            if (c == 2'b00) begin
                chk("stop_go", go, 0);
                chk("stop_idle", idle, 1);
                chk("stop_strt", mnv_strt, 0);
                line_present = 1'b1;
                break;
            end
            exp_mnv = c;
            chk("gap_mnv", mnv, exp_mnv);
            chk("gap_strt", mnv_strt, 1);
            chk("gap_go", go, 1);
            line_present = 1'b1;
            tick();
            chk("gap_strt_1cyc", mnv_strt, 0);
            man = 1'b1;
            if (mode == 1 && $urandom_range(0, 2) == 0)
                bump_seq($urandom_range(1, 3), 1'b1, 1'($urandom_range(0, 1)), man);
            if (man) begin
                mnv_done = 1'b1;
                tick();
                mnv_done = 1'b0;
            end
        end
    endtask

    initial begin
        bit          man;
        logic [15:0] cur;
        logic [15:0] r;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_go", go, 0);
        chk("rst_idle", idle, 1);
        chk("rst_cnt", plan_cnt, 0);
        chk("rst_full", plan_full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_mnv", mnv, 0);
        chk("rst_strt", mnv_strt, 0);
        chk("rst_buzz", buzz_en, 0);
        tick();
        chk("idle_no_pop_go", go, 0);

        start_plan(16'h0005);
        run_plan(16'h0005, 0);

        start_plan(16'h002D);
        run_plan(16'h002D, 2);

        start_plan(16'hFFFF);
        run_plan(16'hFFFF, 0);

        // 3-cycle bump during turn-around, with a plan pushed while blocked
        start_plan(16'h0003);
        line_present = 1'b1;
        tick();
        tick();
        line_present = 1'b0;
        repeat (8) tick();
        exp_mnv = 2'b11;
        chk("tb_mnv", mnv, 3);
        chk("tb_strt", mnv_strt, 1);
        line_present = 1'b1;
        tick();
        bump = 1'b1;
        tick();
        chk("b3_go", go, 0);
        chk("b3_buzz", buzz_en, 1);
        tick();
        tick();
        bump = 1'b0;
        push_plan(16'h0002);
        chk("blk_push_cnt", plan_cnt, 1);
        repeat (14) tick();
        chk("b3_hold_go", go, 0);
        tick();
        chk("b3_clr_go", go, 1);
        chk("b3_clr_buzz", buzz_en, 0);
        chk("b3_restrt", mnv_strt, 1);
        chk("b3_mnv", mnv, 3);
        mnv_done = 1'b1;
        tick();
        mnv_done = 1'b0;
        run_plan(16'h0000, 0);
        tick();
        chk("next_pop_go", go, 1);
        chk("next_pop_cnt", plan_cnt, 0);
        run_plan(16'h0002, 0);

        // maneuver completes while blocked: no re-pulse, back to following
        start_plan(16'h0009);
        line_present = 1'b0;
        repeat (8) tick();
        exp_mnv = 2'b01;
        chk("dn_mnv", mnv, 1);
        line_present = 1'b1;
        tick();
        bump_seq(1, 1'b1, 1'b1, man);
        run_plan(16'h0002, 0);

        // bump in the same cycle a gap would qualify
        start_plan(16'h0001);
        line_present = 1'b1;
        tick();
        tick();
        line_present = 1'b0;
        repeat (7) tick();
        bump = 1'b1;
        tick();
        chk("bg_go", go, 0);
        chk("bg_strt", mnv_strt, 0);
        bump = 1'b0;
        repeat (16) tick();
        chk("bg_clr_go", go, 1);
        chk("bg_clr_strt", mnv_strt, 0);
        repeat (7) tick();
        chk("bg_regap_early", mnv_strt, 0);
        tick();
        chk("bg_regap_strt", mnv_strt, 1);
        chk("bg_regap_mnv", mnv, 1);
        exp_mnv = 2'b01;
        line_present = 1'b1;
        mnv_done = 1'b1;
        tick();
        mnv_done = 1'b0;
        run_plan(16'h0000, 0);

        // FIFO fill, overflow, push+pop at full, then drain in order
        start_plan(16'h0001);
        for (int k = 0; k < 5; k++) begin
            r = 16'($urandom);
            push_plan(r);
            chk("fill_cnt", plan_cnt, (k < 4) ? k+1 : 4);
            if (k < 4) q.push_back(r);
        end
        chk("fill_full", plan_full, 1);
        chk("fill_ovf", ovf, 1);
        run_plan(16'h0001, 0);
        r = 16'($urandom);
        push_plan(r);
        q.push_back(r);
        chk("pushpop_go", go, 1);
        chk("pushpop_cnt", plan_cnt, 4);
        chk("pushpop_full", plan_full, 1);
        cur = q.pop_front();
        forever begin
            run_plan(cur, 1);
            if (q.size() == 0) break;
            tick();
            chk("drain_go", go, 1);
            cur = q.pop_front();
            chk("drain_cnt", plan_cnt, q.size());
        end
        chk("ovf_sticky", ovf, 1);
        tick();
        chk("drained_idle", idle, 1);

        for (int k = 0; k < 3; k++) begin
            r = 16'($urandom);
            start_plan(r);
            run_plan(r, 1);
        end

        // reset mid-maneuver with two plans queued
        start_plan(16'h0003);
        line_present = 1'b0;
        repeat (8) tick();
        chk("rm_strt", mnv_strt, 1);
        line_present = 1'b1;
        push_plan(16'h1234);
        push_plan(16'h0001);
        chk("rm_cnt", plan_cnt, 2);
        rst = 1'b1;
        tick();
        exp_mnv = 2'b00;
        chk("rm_go", go, 0);
        chk("rm_cnt0", plan_cnt, 0);
        chk("rm_idle", idle, 1);
        chk("rm_buzz", buzz_en, 0);
        chk("rm_mnv", mnv, exp_mnv);
        chk("rm_ovf", ovf, 0);
        chk("rm_full", plan_full, 0);
        rst = 1'b0;
        tick();
        chk("rm_after_go", go, 0);
        chk("rm_after_idle", idle, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
